// File: rtl/viterbi_ber_checker.sv
// Viterbi BER checker: learns decoder latency against a tx-bit history, locks, then counts bits and errors.
// Define VITERBI_BER_BURST_EN to add error-burst statistics on burst_ct_o / max_burst_o.
module viterbi_ber_checker #(
   parameter int MAX_LAT     = 64,
   parameter int CNT_W       = 32,
   parameter int LOCK_LEN    = 32,
   parameter int WIN         = 64,
   parameter int LOSS_THRESH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr_i,
   input  logic                       tx_bit_i,
   input  logic                       tx_valid_i,
   input  logic                       rx_bit_i,
   input  logic                       rx_valid_i,
   output logic                       locked_o,
   output logic [$clog2(MAX_LAT)-1:0] lag_o,
   output logic [CNT_W-1:0]           bit_ct_o,
   output logic [CNT_W-1:0]           err_ct_o,
   output logic                       err_o,
   output logic [CNT_W-1:0]           burst_ct_o,
   output logic [15:0]                max_burst_o
);

   localparam int LAG_W  = $clog2(MAX_LAT);
   localparam int FILL_W = $clog2(MAX_LAT + 1);
   localparam int MCT_W  = $clog2(LOCK_LEN + 1);
   localparam int WCT_W  = $clog2(WIN + 1);
   localparam int WER_W  = $clog2(LOSS_THRESH + 1);

   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LAT);
   localparam logic [LAG_W-1:0]  LAG_MAX  = LAG_W'(MAX_LAT - 1);
   localparam logic [MCT_W-1:0]  LOCK_C   = MCT_W'(LOCK_LEN);
   localparam logic [WCT_W-1:0]  WIN_C    = WCT_W'(WIN);
   localparam logic [WER_W-1:0]  LOSS_C   = WER_W'(LOSS_THRESH);

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   state_e             state_q;
   logic [MAX_LAT-1:0] hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [LAG_W-1:0]   lag_q, lag_next;
   logic [MCT_W-1:0]   match_ct_q, match_inc;
   logic [WCT_W-1:0]   win_ct_q, win_inc;
   logic [WER_W-1:0]   win_err_q, win_err_inc;
   logic [CNT_W-1:0]   bit_ct_q, bit_ct_d;
   logic [CNT_W-1:0]   err_ct_q, err_ct_d;
   logic               err_q;
   logic               cmp_en;
   logic               mism;
   logic               lose_lock;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      if (tx_valid_i) begin
         hist_d = {hist_q[MAX_LAT-2:0], tx_bit_i};
         if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
      end

      // The compare bit comes from the pre-shift history, so a same-cycle tx bit is never seen.
      cmp_en      = rx_valid_i && (fill_q > FILL_W'(lag_q));
      mism        = hist_q[lag_q] ^ rx_bit_i;
      match_inc   = match_ct_q + 1'b1;
      win_inc     = win_ct_q + 1'b1;
      win_err_inc = win_err_q + 1'b1;
      lag_next    = (lag_q == LAG_MAX) ? '0 : lag_q + 1'b1;
      bit_ct_d    = (&bit_ct_q) ? bit_ct_q : bit_ct_q + 1'b1;
      err_ct_d    = (&err_ct_q) ? err_ct_q : err_ct_q + 1'b1;
      lose_lock   = (state_q == ST_LOCKED) && cmp_en && mism && (win_err_inc == LOSS_C);
   end

   // NOTE: history and fill are reset along with the control state so a stale history can never
   // satisfy the lag search right after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_SEARCH;
         hist_q     <= '0;
         fill_q     <= '0;
         lag_q      <= '0;
         match_ct_q <= '0;
         win_ct_q   <= '0;
         win_err_q  <= '0;
         bit_ct_q   <= '0;
         err_ct_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register update based on pre-edge values.
         hist_q <= hist_d;
         fill_q <= fill_d;
         err_q  <= 1'b0;
         if (clr_i) begin
            state_q    <= ST_SEARCH;
            lag_q      <= '0;
            match_ct_q <= '0;
            win_ct_q   <= '0;
            win_err_q  <= '0;
            bit_ct_q   <= '0;
            err_ct_q   <= '0;
         end else if (cmp_en) begin
            case (state_q)
               ST_SEARCH: begin
                  if (mism) begin
                     match_ct_q <= '0;
                     lag_q      <= lag_next;
                  end else if (match_inc == LOCK_C) begin
                     state_q    <= ST_LOCKED;
                     match_ct_q <= '0;
                     win_ct_q   <= '0;
                     win_err_q  <= '0;
                  end else begin
                     match_ct_q <= match_inc;
                  end
               end
               ST_LOCKED: begin
                  bit_ct_q <= bit_ct_d;
                  if (mism) begin
                     err_ct_q <= err_ct_d;
                     err_q    <= 1'b1;
                  end
                  // Threshold is tested before the window wraps, so an error on the last bit still counts.
                  if (lose_lock) begin
                     state_q    <= ST_SEARCH;
                     lag_q      <= '0;
                     match_ct_q <= '0;
                     win_ct_q   <= '0;
                     win_err_q  <= '0;
                  end else if (win_inc == WIN_C) begin
                     win_ct_q  <= '0;
                     win_err_q <= '0;
                  end else begin
                     win_ct_q <= win_inc;
                     if (mism) win_err_q <= win_err_inc;
                  end
               end
               default: state_q <= ST_SEARCH;
            endcase
         end
      end
   end

   assign locked_o = (state_q == ST_LOCKED);
   assign lag_o    = lag_q;
   assign bit_ct_o = bit_ct_q;
   assign err_ct_o = err_ct_q;
   assign err_o    = err_q;

`ifdef VITERBI_BER_BURST_EN
   logic [15:0]      burst_len_q, burst_len_inc;
   logic [CNT_W-1:0] burst_ct_q, burst_ct_inc;
   logic [15:0]      max_burst_q;

   always_comb begin
      burst_len_inc = (&burst_len_q) ? burst_len_q : burst_len_q + 1'b1;
      burst_ct_inc  = (&burst_ct_q) ? burst_ct_q : burst_ct_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         burst_len_q <= '0;
         burst_ct_q  <= '0;
         max_burst_q <= '0;
      end else if (clr_i) begin
         burst_len_q <= '0;
         burst_ct_q  <= '0;
         max_burst_q <= '0;
      end else if (state_q == ST_LOCKED && cmp_en) begin
         if (mism) begin
            if (burst_len_q == '0) burst_ct_q <= burst_ct_inc;
            if (burst_len_inc > max_burst_q) max_burst_q <= burst_len_inc;
            // The bit that drops lock still belongs to the run, but the run ends with it.
            burst_len_q <= lose_lock ? '0 : burst_len_inc;
         end else begin
            burst_len_q <= '0;
         end
      end
   end

   assign burst_ct_o  = burst_ct_q;
   assign max_burst_o = max_burst_q;
`else
   assign burst_ct_o  = '0;
   assign max_burst_o = '0;
`endif

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Directed bench for viterbi_ber_checker: lag search, lock, error counting, loss of lock, reset and clear.
// Burst expectations follow VITERBI_BER_BURST_EN.
module tb_viterbi_ber_checker;

`ifdef VITERBI_BER_BURST_EN
   localparam bit BURST_ON = 1'b1;
`else
   localparam bit BURST_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_i = 1'b0;
   logic        tx_bit_i = 1'b0;
   logic        tx_valid_i = 1'b0;
   logic        rx_bit_i = 1'b0;
   logic        rx_valid_i = 1'b0;
   logic        locked_o;
   logic [5:0]  lag_o;
   logic [31:0] bit_ct_o;
   logic [31:0] err_ct_o;
   logic        err_o;
   logic [31:0] burst_ct_o;
   logic [15:0] max_burst_o;

   viterbi_ber_checker dut (
      .clk         (clk),
      .rst         (rst),
      .clr_i       (clr_i),
      .tx_bit_i    (tx_bit_i),
      .tx_valid_i  (tx_valid_i),
      .rx_bit_i    (rx_bit_i),
      .rx_valid_i  (rx_valid_i),
      .locked_o    (locked_o),
      .lag_o       (lag_o),
      .bit_ct_o    (bit_ct_o),
      .err_ct_o    (err_ct_o),
      .err_o       (err_o),
      .burst_ct_o  (burst_ct_o),
      .max_burst_o (max_burst_o)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   logic txlog [0:8191];
   int   ntx = 0;
   int   true_lag = 5;
   int   lk_bits = 0;
   int   exp_bits = 0;
   int   exp_errs = 0;
   int   exp_bursts = 0;
   int   exp_max = 0;

   // One tx/rx beat: rx carries the tx bit from (true_lag+1) accepted tx bits ago, optionally flipped.
   task automatic step(input logic flip, output logic rxv);
      int idx;
      idx = ntx - 1 - true_lag;
      tx_bit_i   = 1'($urandom_range(1, 0));
      tx_valid_i = 1'b1;
      rxv        = (idx >= 0);
      rx_valid_i = rxv;
      rx_bit_i   = 1'b0;
      if (rxv) rx_bit_i = txlog[idx] ^ flip;
      txlog[ntx] = tx_bit_i;
      @(posedge clk);
      #1;
      ntx++;
      tx_valid_i = 1'b0;
      rx_valid_i = 1'b0;
   endtask

   task automatic clean(input int n, output int pulses);
      logic rxv;
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         step(1'b0, rxv);
         if (err_o) pulses++;
      end
   endtask

   task automatic clr_pulse();
      clr_i = 1'b1;
      @(posedge clk);
      #1;
      clr_i = 1'b0;
   endtask

   task automatic run_search(input int budget, output bit got_lock, output int n_inc,
                             output int since, output bit walk_ok, output bit wrapped);
      logic [5:0] prev;
      logic       rxv;
      got_lock = 1'b0;
      n_inc    = 0;
      since    = 0;
      walk_ok  = 1'b1;
      wrapped  = 1'b0;
      prev     = lag_o;
      for (int i = 0; i < budget; i++) begin
         step(1'b0, rxv);
         if (lag_o != prev) begin
            if (lag_o != prev + 6'd1) walk_ok = 1'b0;
            if (prev == 6'd63 && lag_o == 6'd0) wrapped = 1'b1;
            n_inc++;
            since = 0;
         end else if (rxv) begin
            since++;
         end
         prev = lag_o;
         if (locked_o) begin
            got_lock = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_counts(input string tag);
      n_checks++;
      if (bit_ct_o !== 32'(exp_bits)) begin
         n_errors++;
         $display("FAIL %s bit_ct: got %0d expected %0d", tag, bit_ct_o, exp_bits);
      end
      n_checks++;
      if (err_ct_o !== 32'(exp_errs)) begin
         n_errors++;
         $display("FAIL %s err_ct: got %0d expected %0d", tag, err_ct_o, exp_errs);
      end
      n_checks++;
      if (burst_ct_o !== (BURST_ON ? 32'(exp_bursts) : 32'd0)) begin
         n_errors++;
         $display("FAIL %s burst_ct: got %0d expected %0d", tag, burst_ct_o, BURST_ON ? exp_bursts : 0);
      end
      n_checks++;
      if (max_burst_o !== (BURST_ON ? 16'(exp_max) : 16'd0)) begin
         n_errors++;
         $display("FAIL %s max_burst: got %0d expected %0d", tag, max_burst_o, BURST_ON ? exp_max : 0);
      end
   endtask

   task automatic check_lock(input string tag, input bit got, input int lag);
      n_checks++;
      if (got !== 1'b1 || locked_o !== 1'b1) begin
         n_errors++;
         $display("FAIL %s lock: locked_o=%0b expected 1", tag, locked_o);
      end
      n_checks++;
      if (lag_o !== 6'(lag)) begin
         n_errors++;
         $display("FAIL %s lag: got %0d expected %0d", tag, lag_o, lag);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      #3;
      n_checks++;
      if (locked_o !== 1'b0 || lag_o !== 6'd0 || err_o !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl: locked=%0b lag=%0d err=%0b expected 0 0 0", locked_o, lag_o, err_o);
      end
      check_counts("reset");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (locked_o !== 1'b0 || lag_o !== 6'd0) begin
         n_errors++;
         $display("FAIL reset_idle: locked=%0b lag=%0d expected 0 0", locked_o, lag_o);
      end
   endtask

   task automatic test_lock();
      bit got, walk_ok, wrapped;
      int n_inc, since, pulses;
      true_lag = 5;
      run_search(400, got, n_inc, since, walk_ok, wrapped);
      check_lock("first_lock", got, 5);
      n_checks++;
      if (n_inc !== 5 || since !== 32 || walk_ok !== 1'b1) begin
         n_errors++;
         $display("FAIL lock_path: lag steps=%0d matches=%0d walk=%0b expected 5 32 1", n_inc, since, walk_ok);
      end
      check_counts("at_lock");
      clean(1000, pulses);
      lk_bits  += 1000;
      exp_bits += 1000;
      check_counts("clean_1000");
      n_checks++;
      if (pulses !== 0 || locked_o !== 1'b1) begin
         n_errors++;
         $display("FAIL clean_1000: err pulses=%0d locked=%0b expected 0 1", pulses, locked_o);
      end
   endtask

   task automatic test_errors();
      logic rxv, flip;
      int   bad, pulses;
      bad = 0;
      pulses = 0;
      for (int i = 0; i < 200; i++) begin
         flip = (i >= 100 && i <= 102);
         step(flip, rxv);
         if (err_o) pulses++;
         if (err_o !== flip) bad++;
      end
      lk_bits    += 200;
      exp_bits   += 200;
      exp_errs   += 3;
      exp_bursts += 1;
      exp_max     = 3;
      n_checks++;
      if (pulses !== 3 || bad !== 0) begin
         n_errors++;
         $display("FAIL err_pulses: count=%0d misplaced=%0d expected 3 0", pulses, bad);
      end
      check_counts("three_errors");
   endtask

   task automatic test_loss();
      logic rxv;
      int   early_drop;
      bit   got, walk_ok, wrapped;
      int   n_inc, since;
      early_drop = 0;
      while (lk_bits % 64 != 56) begin
         step(1'b0, rxv);
         lk_bits++;
         exp_bits++;
      end
      // Eight errors fill window slots 56..63, so the last one coincides with the window end.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, rxv);
         if (i < 7 && locked_o !== 1'b1) early_drop++;
      end
      exp_bits   += 8;
      exp_errs   += 8;
      exp_bursts += 1;
      exp_max     = 8;
      n_checks++;
      if (early_drop !== 0) begin
         n_errors++;
         $display("FAIL loss_early: drops before 8th error=%0d expected 0", early_drop);
      end
      n_checks++;
      if (locked_o !== 1'b0 || lag_o !== 6'd0) begin
         n_errors++;
         $display("FAIL loss: locked=%0b lag=%0d expected 0 0", locked_o, lag_o);
      end
      check_counts("after_loss");
      run_search(400, got, n_inc, since, walk_ok, wrapped);
      check_lock("relock", got, 5);
      check_counts("relock");
      lk_bits = 0;
   endtask

   task automatic test_window_7();
      logic rxv, flip;
      int   drops;
      drops = 0;
      for (int w = 0; w < 3; w++) begin
         for (int p = 0; p < 64; p++) begin
            flip = (p >= 50) && (p % 2 == 0);
            step(flip, rxv);
            if (locked_o !== 1'b1) drops++;
         end
         exp_bits += 64;
         exp_errs += 7;
         n_checks++;
         if (err_ct_o !== 32'(exp_errs)) begin
            n_errors++;
            $display("FAIL window7_err_ct w%0d: got %0d expected %0d", w, err_ct_o, exp_errs);
         end
      end
      lk_bits    += 192;
      exp_bursts += 21;
      n_checks++;
      if (drops !== 0) begin
         n_errors++;
         $display("FAIL window7_lock: unlocked beats=%0d expected 0", drops);
      end
      check_counts("window7");
   endtask

   task automatic test_lag_limits();
      bit got, walk_ok, wrapped;
      int n_inc, since;
      clr_pulse();
      exp_bits = 0; exp_errs = 0; exp_bursts = 0; exp_max = 0;
      true_lag = 63;
      run_search(3000, got, n_inc, since, walk_ok, wrapped);
      check_lock("lag63", got, 63);
      n_checks++;
      if (n_inc !== 63 || since !== 32 || walk_ok !== 1'b1) begin
         n_errors++;
         $display("FAIL lag63_path: lag steps=%0d matches=%0d walk=%0b expected 63 32 1", n_inc, since, walk_ok);
      end
      check_counts("lag63");
      clr_pulse();
      true_lag = 70;
      run_search(700, got, n_inc, since, walk_ok, wrapped);
      n_checks++;
      if (got !== 1'b0 || wrapped !== 1'b1 || walk_ok !== 1'b1) begin
         n_errors++;
         $display("FAIL lag70: locked=%0b wrapped=%0b walk=%0b expected 0 1 1", got, wrapped, walk_ok);
      end
   endtask

   task automatic test_reset_clr();
      bit got, walk_ok, wrapped;
      int n_inc, since, pulses;
      clr_pulse();
      true_lag = 5;
      run_search(600, got, n_inc, since, walk_ok, wrapped);
      check_lock("pre_reset_lock", got, 5);
      clean(20, pulses);
      #2;
      rst = 1'b0;
      #1;
      exp_bits = 0; exp_errs = 0; exp_bursts = 0; exp_max = 0;
      n_checks++;
      if (locked_o !== 1'b0 || lag_o !== 6'd0 || err_o !== 1'b0) begin
         n_errors++;
         $display("FAIL async_reset: locked=%0b lag=%0d err=%0b expected 0 0 0", locked_o, lag_o, err_o);
      end
      check_counts("async_reset");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      run_search(600, got, n_inc, since, walk_ok, wrapped);
      check_lock("post_reset_lock", got, 5);
      clean(30, pulses);
      exp_bits = 30;
      check_counts("post_reset_bits");
      // Clear wins over a same-cycle locked mismatch.
      clr_i      = 1'b1;
      rx_valid_i = 1'b1;
      rx_bit_i   = ~txlog[ntx - 1 - true_lag];
      @(posedge clk);
      #1;
      clr_i      = 1'b0;
      rx_valid_i = 1'b0;
      exp_bits = 0;
      n_checks++;
      if (locked_o !== 1'b0 || lag_o !== 6'd0 || err_o !== 1'b0) begin
         n_errors++;
         $display("FAIL clr: locked=%0b lag=%0d err=%0b expected 0 0 0", locked_o, lag_o, err_o);
      end
      check_counts("clr");
      // A mismatch at lag 0 only advances the lag if the history survived the clear.
      rx_valid_i = 1'b1;
      rx_bit_i   = ~txlog[ntx - 1];
      @(posedge clk);
      #1;
      rx_valid_i = 1'b0;
      n_checks++;
      if (lag_o !== 6'd1 || locked_o !== 1'b0) begin
         n_errors++;
         $display("FAIL clr_history: lag=%0d locked=%0b expected 1 0", lag_o, locked_o);
      end
      run_search(400, got, n_inc, since, walk_ok, wrapped);
      check_lock("clr_relock", got, 5);
      check_counts("clr_relock");
   endtask

   initial begin
      test_reset();
      test_lock();
      test_errors();
      test_loss();
      test_window_7();
      test_lag_limits();
      test_reset_clr();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/viterbi_ber_checker.md
Name: viterbi_ber_checker

Overview:
- Receive-side bit-error-rate checker for the encoder/channel/Viterbi decoder chain.
- Stores transmitted information bits (encoder input side) in a history shift register.
- Automatically finds the decoder's end-to-end latency (lag), locks to it, then compares every decoded bit against the aligned transmitted bit, counting bits and errors.
- Sits beside the decoder in the tx/rx test wrapper and replaces ad-hoc $display error bookkeeping with synthesizable counters.

Parameters:
- MAX_LAT, 64: history depth; legal lag range 0..MAX_LAT-1 (tx-valid events).
- CNT_W, 32: width of bit and error counters.
- LOCK_LEN, 32: consecutive matches in SEARCH needed to declare lock.
- WIN, 64: LOCKED-state monitoring window, in rx-valid bits.
- LOSS_THRESH, 8: errors within one window that force loss of lock.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- clr_i  input  1  synchronous clear: counters to 0, state to SEARCH, lag to 0; history kept
- tx_bit_i  input  1  transmitted information bit (encoder d_in)
- tx_valid_i  input  1  tx_bit_i qualifier (encoder enable)
- rx_bit_i  input  1  decoded bit (decoder d_out)
- rx_valid_i  input  1  rx_bit_i qualifier
- locked_o  output  1  1 in LOCKED
- lag_o  output  $clog2(MAX_LAT)  current candidate lag in SEARCH, locked lag in LOCKED
- bit_ct_o  output  CNT_W  bits compared while LOCKED
- err_ct_o  output  CNT_W  mismatches while LOCKED
- err_o  output  1  one-cycle pulse, registered, for each LOCKED mismatch
- burst_ct_o  output  CNT_W  error bursts (see Optional Feature)
- max_burst_o  output  16  longest burst (see Optional Feature)

Behaviour:
- Reset (rst=0, async): all outputs 0, state SEARCH, lag 0, history and fill count 0, match/window counters 0.
- History: on tx_valid_i, hist <= {hist[MAX_LAT-2:0], tx_bit_i}. fill counts valid entries and saturates at MAX_LAT.
- Compare bit: hist[lag] is taken from the registered history before the current cycle's shift. Lag 0 = most recent previously accepted tx bit.
- Simultaneous tx_valid_i and rx_valid_i: compare against the old history, then shift.
- Comparisons occur only on rx_valid_i. Result registers are updated the next edge (1-cycle latency for err_o and counters).
- SEARCH:
  - If fill <= lag: no-op (neither match nor mismatch).
  - Match: match_ct+1. When match_ct reaches LOCK_LEN, go to LOCKED on that edge. match_ct and window counters are cleared.
  - Mismatch: match_ct=0, lag+1. Lag wraps from MAX_LAT-1 to 0.
  - bit_ct_o and err_ct_o do not change in SEARCH.
- LOCKED:
  - Each rx_valid_i: bit_ct+1 and win_ct+1. On mismatch also err_ct+1, win_err+1, and err_o=1 for one cycle.
  - When win_ct reaches WIN, win_ct and win_err are cleared.
  - If win_err reaches LOSS_THRESH: go to SEARCH, lag=0, match_ct=0. Totals are retained.
  - A mismatch and the window end on the same bit: the error counts toward the threshold first, then the window clears.
- Counters bit_ct and err_ct saturate at all-ones and never wrap.
- clr_i has priority over all same-cycle updates except async reset.
- Reset asserted mid-operation: immediate return to reset values; no partial counts survive.

Optional Feature:
- Macro: VITERBI_BER_BURST_EN.
- Defined:
  - A burst is a maximal run of LOCKED mismatches on consecutive rx-valid bits.
  - burst_ct_o increments on the first errored bit of each run and saturates.
  - The run length is tracked in a 16-bit counter that saturates at 16'hFFFF.
  - max_burst_o updates as soon as the running length exceeds it.
  - Any correct bit, loss of lock, or clr_i ends the run.
- Not defined: burst_ct_o and max_burst_o are tied to 0 and no burst logic is synthesized.

Test Plan:
- Random tx, rx = tx delayed by 5 tx-valid events, no errors -> locked_o rises after 5 mismatch steps + 32 matches; lag_o=5; after 1000 further bits bit_ct_o=1000, err_ct_o=0.
- Locked at lag 5, flip rx bits 100, 101, 102 -> err_ct_o=3, three err_o pulses one cycle after each; with macro burst_ct_o=1, max_burst_o=3.
- Locked, inject 8 errors within one 64-bit window -> locked_o falls the cycle after the 8th error, lag_o=0, err_ct_o retained; relock at lag 5.
- Inject 7 errors per window repeatedly -> stays locked; err_ct_o grows by 7 per window.
- True lag 63 -> lag walks through 0..62 and locks at 63. True lag > 63 -> lag wraps 63->0 and locked_o never asserts.
- Assert rst mid-LOCKED, then clr_i during LOCKED -> outputs to 0 asynchronously; clr_i clears counters next edge, lag_o=0, locked_o=0, history preserved (relock needs no refill).
